// File: rtl/ethernet_tx_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_tx_mmio_pkg
// Description : Shared definitions for the Ethernet TX MMIO master. Holds the
//               controller register map (14-bit byte addresses) and the FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ethernet_tx_mmio_pkg;

    // Controller register map (byte addresses)
    localparam logic [13:0] TX_BUF_BASE   = 14'h0800;  // start of TX packet buffer
    localparam logic [13:0] TX_SEND_ADDR  = 14'h1018;  // write 1 to launch the frame
    localparam logic [13:0] TX_READY_ADDR = 14'h1020;  // bit0 = buffer free
    localparam logic [13:0] TX_SIZE_ADDR  = 14'h1028;  // frame length in bytes

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POLL      = 3'd1,
        POLL_WAIT = 3'd2,
        FILL      = 3'd3,
        DRAIN     = 3'd4,
        SIZE      = 3'd5,
        SEND      = 3'd6
    } tx_state_e;

endpackage : ethernet_tx_mmio_pkg
`default_nettype wire

// File: rtl/bsg_popcount.sv
`default_nettype none
// ============================================================================
// Module      : bsg_popcount
// Description : Combinational population count of a bit vector.
// Ports       : i_a     - input vector (WIDTH_P bits)
//               o_count - number of ones in i_a ($clog2(WIDTH_P+1) bits)
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_popcount #(
    parameter int WIDTH_P = 4
) (
    input  logic [WIDTH_P-1:0]            i_a,
    output logic [$clog2(WIDTH_P+1)-1:0]  o_count
);

    localparam int c_CNT_W = $clog2(WIDTH_P + 1);

    always_comb begin
        o_count = '0;
        for (int k = 0; k < WIDTH_P; k++) begin
            o_count = o_count + c_CNT_W'(i_a[k]);
        end
    end

endmodule : bsg_popcount
`default_nettype wire

// File: rtl/ethernet_tx_mmio_master.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_tx_mmio_master
// Description : Moves one packet at a time from a valid/ready word stream into
//               a MMIO Ethernet TX controller: polls TX_READY, copies the
//               packet words into the TX buffer, writes the byte count to
//               TX_SIZE and then kicks TX_SEND. Packets longer than the MTU
//               are drained from the stream and reported on drop_o.
// Ports       : clk_i, reset_n_i        - clock, synchronous active-low reset
//               pkt_data_i/keep/v/last  - packet stream in, pkt_ready_o out
//               addr_o, write_en_o, read_en_o, write_mask_o, write_data_o,
//               read_data_i             - MMIO master (1-cycle read latency)
//               done_o, drop_o, busy_o  - status
// Revision    : 1.0 - initial release
// ============================================================================
module ethernet_tx_mmio_master
    import ethernet_tx_mmio_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int eth_mtu_p    = 2048
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [data_width_p-1:0]   pkt_data_i,
    input  logic [data_width_p/8-1:0] pkt_keep_i,
    input  logic                      pkt_v_i,
    input  logic                      pkt_last_i,
    output logic                      pkt_ready_o,
    output logic [13:0]               addr_o,
    output logic                      write_en_o,
    output logic                      read_en_o,
    output logic [data_width_p/8-1:0] write_mask_o,
    output logic [data_width_p-1:0]   write_data_o,
    input  logic [data_width_p-1:0]   read_data_i,
    output logic                      done_o,
    output logic                      drop_o,
    output logic                      busy_o
);

    localparam int c_BYTES = data_width_p / 8;
    localparam int c_CNT_W = $clog2(eth_mtu_p + 1);
    localparam int c_POP_W = $clog2(c_BYTES + 1);

    tx_state_e                 r_state;
    tx_state_e                 w_next_state;
    logic [c_CNT_W-1:0]        r_byte_cnt;
    logic [c_CNT_W-1:0]        w_next_byte_cnt;

    logic [c_POP_W-1:0]        w_keep_cnt;
    logic [c_CNT_W:0]          w_incoming;
    logic [c_CNT_W:0]          w_sum;
    logic                      w_over;

    logic                      w_ready;
    logic                      w_wen;
    logic                      w_ren;
    logic [13:0]               w_addr;
    logic [data_width_p-1:0]   w_wdata;
    logic [c_BYTES-1:0]        w_wmask;
    logic                      w_done;
    logic                      w_drop;

    // Only the ready flag of the TX_READY register is meaningful.
    logic                      w_unused_rd_bits;
    assign w_unused_rd_bits = ^read_data_i[data_width_p-1:1];

    bsg_popcount #(
        .WIDTH_P (c_BYTES)
    ) u_keep_popcount (
        .i_a     (pkt_keep_i),
        .o_count (w_keep_cnt)
    );

    // Non-last words are always full; only the last word may be partial.
    // One spare bit on the sum so an MTU overrun is never lost to wrap.
    assign w_incoming = pkt_last_i ? (c_CNT_W+1)'(w_keep_cnt) : (c_CNT_W+1)'(c_BYTES);
    assign w_sum      = {1'b0, r_byte_cnt} + w_incoming;
    assign w_over     = (w_sum > (c_CNT_W+1)'(eth_mtu_p));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_byte_cnt <= w_next_byte_cnt;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_byte_cnt = r_byte_cnt;
        w_ready         = 1'b0;
        w_wen           = 1'b0;
        w_ren           = 1'b0;
        w_addr          = '0;
        w_wdata         = '0;
        w_wmask         = '0;
        w_done          = 1'b0;
        w_drop          = 1'b0;

        case (r_state)
            IDLE: begin
                if (pkt_v_i) begin
                    w_next_state = POLL;
                end
            end

            POLL: begin
                w_ren        = 1'b1;
                w_addr       = TX_READY_ADDR;
                w_next_state = POLL_WAIT;
            end

            POLL_WAIT: begin
                if (read_data_i[0]) begin
                    w_next_state    = FILL;
                    w_next_byte_cnt = '0;
                end else begin
                    w_next_state = POLL;
                end
            end

            FILL: begin
                w_ready = 1'b1;
                if (pkt_v_i) begin
                    if (w_over) begin
                        // The overflowing word is never written.
                        if (pkt_last_i) begin
                            w_drop       = 1'b1;
                            w_next_state = IDLE;
                        end else begin
                            w_next_state = DRAIN;
                        end
                    end else begin
                        w_wen           = 1'b1;
                        w_addr          = TX_BUF_BASE + 14'(r_byte_cnt);
                        w_wdata         = pkt_data_i;
                        w_wmask         = pkt_keep_i;
                        w_next_byte_cnt = w_sum[c_CNT_W-1:0];
                        if (pkt_last_i) begin
                            w_next_state = SIZE;
                        end
                    end
                end
            end

            DRAIN: begin
                w_ready = 1'b1;
                if (pkt_v_i && pkt_last_i) begin
                    w_drop       = 1'b1;
                    w_next_state = IDLE;
                end
            end

            SIZE: begin
                w_wen        = 1'b1;
                w_addr       = TX_SIZE_ADDR;
                w_wdata      = data_width_p'(r_byte_cnt);
                w_wmask      = '1;
                w_next_state = SEND;
            end

            SEND: begin
                w_wen        = 1'b1;
                w_addr       = TX_SEND_ADDR;
                w_wdata      = data_width_p'(1);
                w_wmask      = '1;
                w_done       = 1'b1;
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held so nothing leaks out in
    // the cycle a mid-packet reset is applied.
    assign pkt_ready_o  = reset_n_i & w_ready;
    assign write_en_o   = reset_n_i & w_wen;
    assign read_en_o    = reset_n_i & w_ren;
    assign addr_o       = reset_n_i ? w_addr  : '0;
    assign write_data_o = reset_n_i ? w_wdata : '0;
    assign write_mask_o = reset_n_i ? w_wmask : '0;
    assign done_o       = reset_n_i & w_done;
    assign drop_o       = reset_n_i & w_drop;
    assign busy_o       = reset_n_i & (r_state != IDLE);

endmodule : ethernet_tx_mmio_master
`default_nettype wire

// File: tb/tb_ethernet_tx_mmio_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ethernet_tx_mmio_master
// Description : Directed self-checking bench for ethernet_tx_mmio_master.
//               A 32-bit and a 64-bit instance share one stimulus bus; only
//               the selected instance sees pkt_v. A model of the controller
//               answers TX_READY reads and every MMIO write is logged.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ethernet_tx_mmio_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;          // 0: 32-bit instance, 1: 64-bit instance
    logic [63:0] pdata = '0;
    logic [7:0]  pkeep = '0;
    logic        pv = 1'b0;
    logic        plast = 1'b0;
    logic [63:0] rd_data;

    always #5 clk = ~clk;

    logic        r32, wen32, ren32, done32, drop32, busy32;
    logic [13:0] a32;
    logic [31:0] wd32;
    logic [3:0]  wm32;
    logic        r64, wen64, ren64, done64, drop64, busy64;
    logic [13:0] a64;
    logic [63:0] wd64;
    logic [7:0]  wm64;
    logic        w_ready;
    logic        pv32, pv64;

    assign pv32    = pv & ~sel;
    assign pv64    = pv & sel;
    assign w_ready = sel ? r64 : r32;

    ethernet_tx_mmio_master #(.data_width_p(32), .eth_mtu_p(2048)) dut32 (
        .clk_i(clk), .reset_n_i(reset_n),
        .pkt_data_i(pdata[31:0]), .pkt_keep_i(pkeep[3:0]), .pkt_v_i(pv32),
        .pkt_last_i(plast), .pkt_ready_o(r32), .addr_o(a32),
        .write_en_o(wen32), .read_en_o(ren32), .write_mask_o(wm32),
        .write_data_o(wd32), .read_data_i(rd_data[31:0]),
        .done_o(done32), .drop_o(drop32), .busy_o(busy32)
    );

    ethernet_tx_mmio_master #(.data_width_p(64), .eth_mtu_p(2048)) dut64 (
        .clk_i(clk), .reset_n_i(reset_n),
        .pkt_data_i(pdata), .pkt_keep_i(pkeep), .pkt_v_i(pv64),
        .pkt_last_i(plast), .pkt_ready_o(r64), .addr_o(a64),
        .write_en_o(wen64), .read_en_o(ren64), .write_mask_o(wm64),
        .write_data_o(wd64), .read_data_i(rd_data),
        .done_o(done64), .drop_o(drop64), .busy_o(busy64)
    );

    // ---------------- controller model: TX_READY answers -----------------
    logic [0:0]  rdy_seq [0:7];
    int          rdy_len = 0;
    int          rdy_base = 0;
    int          rd_total = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin : p_resp
        int idx;
        if (!reset_n) begin
            rd_data <= '0;
        end else if (ren32 || ren64) begin
            idx = rd_total - rdy_base;
            rd_data  <= {63'b0, (idx < rdy_len) ? rdy_seq[idx] : 1'b1};
            rd_total <= rd_total + 1;
        end
    end

    // ---------------- MMIO write log and event counters -----------------
    logic [13:0] lg_addr [0:4095];
    logic [63:0] lg_data [0:4095];
    logic [7:0]  lg_mask [0:4095];
    int          lg_cyc  [0:4095];
    int          wr_n = 0, done_n = 0, drop_n = 0, ovl_n = 0, bad_rd_n = 0;

    always @(negedge clk) begin
        if (wr_n < 4096 && (wen32 || wen64)) begin
            lg_addr[wr_n] = wen32 ? a32 : a64;
            lg_data[wr_n] = wen32 ? {32'b0, wd32} : wd64;
            lg_mask[wr_n] = wen32 ? {4'b0, wm32} : wm64;
            lg_cyc[wr_n]  = cyc;
        end
        if (wen32 || wen64) wr_n = wr_n + 1;
        if ((ren32 && a32 != 14'h1020) || (ren64 && a64 != 14'h1020)) bad_rd_n = bad_rd_n + 1;
        if ((wen32 && ren32) || (wen64 && ren64)) ovl_n = ovl_n + 1;
        done_n = done_n + int'(done32) + int'(done64);
        drop_n = drop_n + int'(drop32) + int'(drop64);
    end

    // ---------------- checking helpers -----------------
    int n_tot = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot = n_tot + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input int p, input int i, input int nbytes, input int nb);
        logic [63:0] w = '0;
        for (int k = 0; k < nb; k++)
            if (i * nb + k < nbytes) w[8*k +: 8] = 8'(p * 37 + i * nb + k);
        return w;
    endfunction

    function automatic logic [7:0] keep_of(input int i, input int nw, input int nbytes, input int nb);
        if (i < nw - 1) return 8'((1 << nb) - 1);
        return 8'((1 << (nbytes - i * nb)) - 1);
    endfunction

    // Drive up to stop_after words; rwait counts non-ready cycles before word 0.
    task automatic send_pkt(input int nbytes, input int p, input int stop_after,
                            output int rwait, output int last_cyc);
        int  nb = sel ? 8 : 4;
        int  nw = (nbytes == 0) ? 1 : (nbytes + nb - 1) / nb;
        bit  acc;
        int  guard;
        rwait = 0;
        last_cyc = 0;
        for (int i = 0; i < nw && i < stop_after; i++) begin
            pdata = word_of(p, i, nbytes, nb);
            pkeep = keep_of(i, nw, nbytes, nb);
            plast = (i == nw - 1);
            pv    = 1'b1;
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 1000) begin
                @(negedge clk);
                if (w_ready) begin
                    acc = 1'b1;
                    last_cyc = cyc;
                end else if (i == 0) begin
                    rwait = rwait + 1;
                end
                guard = guard + 1;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        pv = 1'b0;
        plast = 1'b0;
    endtask

    task automatic wait_end(input int start);
        int g = 0;
        while (done_n + drop_n == start && g < 50) begin
            @(posedge clk);
            #1;
            g = g + 1;
        end
        if (done_n + drop_n == start) chk("end_timeout", 64'd0, 64'd1);
    endtask

    // Full packet: send, wait, then check the write log against the stimulus.
    task automatic run_pkt(input string tag, input int nbytes, input int p, input int nwr,
                           input bit sent, input int exp_reads, input int exp_rwait);
        int nb = sel ? 8 : 4;
        int wb = wr_n, db = done_n, xb = drop_n, rb = rd_total;
        int rw, lc;
        int nw = (nbytes == 0) ? 1 : (nbytes + nb - 1) / nb;
        rdy_base = rd_total;
        send_pkt(nbytes, p, 100000, rw, lc);
        wait_end(db + xb);
        for (int i = 0; i < nwr; i++) begin
            chk({tag, ".addr"}, 64'(lg_addr[wb+i]), 64'(32'h800 + i * nb));
            chk({tag, ".data"}, lg_data[wb+i], word_of(p, i, nbytes, nb));
            chk({tag, ".mask"}, 64'(lg_mask[wb+i]), 64'(keep_of(i, nw, nbytes, nb)));
        end
        chk({tag, ".reads"}, 64'(rd_total - rb), 64'(exp_reads));
        chk({tag, ".ready_wait"}, 64'(rw), 64'(exp_rwait));
        if (sent) begin
            chk({tag, ".nwrites"}, 64'(wr_n - wb), 64'(nwr + 2));
            chk({tag, ".size_addr"}, 64'(lg_addr[wb+nwr]), 64'h1028);
            chk({tag, ".size_data"}, lg_data[wb+nwr], 64'(nbytes));
            chk({tag, ".size_mask"}, 64'(lg_mask[wb+nwr]), sel ? 64'hFF : 64'h0F);
            chk({tag, ".send_addr"}, 64'(lg_addr[wb+nwr+1]), 64'h1018);
            chk({tag, ".send_data"}, lg_data[wb+nwr+1], 64'd1);
            chk({tag, ".send_latency"}, 64'(lg_cyc[wb+nwr+1] - lc), 64'd2);
            chk({tag, ".done"}, 64'(done_n - db), 64'd1);
            chk({tag, ".drop"}, 64'(drop_n - xb), 64'd0);
        end else begin
            chk({tag, ".nwrites"}, 64'(wr_n - wb), 64'(nwr));
            chk({tag, ".done"}, 64'(done_n - db), 64'd0);
            chk({tag, ".drop"}, 64'(drop_n - xb), 64'd1);
        end
    endtask

    task automatic chk_quiet(input string tag);
        @(negedge clk);
        chk({tag, ".out32"}, 64'({r32, wen32, ren32, done32, drop32, busy32, a32, wd32, wm32}), 64'd0);
        chk({tag, ".out64"}, 64'({r64, wen64, ren64, done64, drop64, busy64, a64}), 64'd0);
        chk({tag, ".data64"}, {wd64[55:0], wm64}, 64'd0);
    endtask

    // ---------------- directed sequence -----------------
    initial begin : p_main
        int wb, db, rw, lc;

        rdy_seq[0] = 1'b0; rdy_seq[1] = 1'b0; rdy_seq[2] = 1'b1;
        repeat (2) @(posedge clk);
        chk_quiet("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 60 bytes, ready on the first poll
        rdy_len = 0;
        run_pkt("p60", 60, 1, 15, 1'b1, 1, 3);
        // 61 bytes: last word carries one byte
        wb = wr_n;
        run_pkt("p61", 61, 2, 16, 1'b1, 1, 3);
        chk("p61.last_addr", 64'(lg_addr[wb+15]), 64'h083C);
        chk("p61.last_mask", 64'(lg_mask[wb+15]), 64'h01);
        // TX_READY reads 0,0,1
        rdy_len = 3;
        run_pkt("poll3", 16, 3, 4, 1'b1, 3, 7);
        rdy_len = 0;
        // zero-length packet
        run_pkt("zero", 0, 4, 1, 1'b1, 1, 3);
        // exactly MTU
        run_pkt("mtu", 2048, 5, 512, 1'b1, 1, 3);
        // one word past MTU, overflowing word is last
        wb = wr_n;
        run_pkt("p2052", 2052, 6, 512, 1'b0, 1, 3);
        chk("p2052.top_addr", 64'(lg_addr[wb+511]), 64'h0FFC);
        // oversize with words left to drain
        run_pkt("p2060", 2060, 7, 512, 1'b0, 1, 3);
        // next packet after a drop
        run_pkt("after_drop", 8, 8, 2, 1'b1, 1, 3);

        // reset after the 5th FILL word
        wb = wr_n;
        db = done_n;
        rdy_base = rd_total;
        send_pkt(60, 9, 5, rw, lc);
        chk("rst.words", 64'(wr_n - wb), 64'd5);
        reset_n = 1'b0;
        @(posedge clk);
        chk_quiet("rst.hold");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst.no_size_send", 64'(wr_n - wb), 64'd5);
        chk("rst.no_done", 64'(done_n - db), 64'd0);
        run_pkt("rst.fresh", 60, 10, 15, 1'b1, 1, 3);

        // 64-bit instance: two back-to-back 64-byte packets
        sel = 1'b1;
        run_pkt("w64.a", 64, 11, 8, 1'b1, 1, 3);
        run_pkt("w64.b", 64, 12, 8, 1'b1, 1, 3);

        chk("no_rw_overlap", 64'(ovl_n), 64'd0);
        chk("read_addr", 64'(bad_rd_n), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_ethernet_tx_mmio_master
`default_nettype wire
